integer_exec_unit: RTL

//   Integer execution unit fed by the integer issue queue; pops one ready instruction per cycle.
//   Two stages: EX operand register, then ALU compute into a result buffer.

---
 rtl/integer_exec_unit_pkg.sv | 43 ++++
 rtl/integer_exec_unit_alu.sv | 27 ++
 rtl/integer_exec_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/integer_exec_unit_pkg.sv
// Shared types and constants for the integer execution unit.
// INT_EXU_RESULT_BUF_EN: when defined the result buffer is a 2-entry FIFO,
// otherwise a single result register.
package integer_exec_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned OPC_W = 3;

`ifdef INT_EXU_RESULT_BUF_EN
  localparam int unsigned RES_DEPTH = 2;
`else
  localparam int unsigned RES_DEPTH = 1;
`endif

  // Occupancy counter must hold 0..RES_DEPTH inclusive.
  localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);

  typedef enum logic [OPC_W-1:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluSlt = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rd_tag;
    alu_op_e          opcode;
    logic [XLEN-1:0]  rs_data;
    logic [XLEN-1:0]  rt_data;
  } exu_entry_t;

  typedef struct packed {
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  data;
  } exu_result_t;

endpackage

// File: rtl/integer_exec_unit_alu.sv
// Purely combinational integer ALU used by the EX stage.
module int_alu
  import integer_exec_unit_pkg::*;
(
  input  alu_op_e         opcode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  // Decode the opcode; shifts use only the low five bits of b.
  always_comb begin
    result = '0;
    unique case (opcode)
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluXor:  result = a ^ b;
      AluSll:  result = a << b[4:0];
      AluSrl:  result = a >> b[4:0];
      AluSlt:  result = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/integer_exec_unit.sv
// Integer execution unit: EX operand register, ALU, result buffer and CDB
// request/grant handshake. Buffer depth selected by INT_EXU_RESULT_BUF_EN.
module integer_exec_unit
  import integer_exec_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             issueque_ready,
  input  logic [XLEN-1:0]  issueque_rs_data,
  input  logic [XLEN-1:0]  issueque_rt_data,
  input  logic [TAG_W-1:0] issueque_rd_tag,
  input  logic [OPC_W-1:0] issueque_opcode,
  output logic             issueblk_done,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] exu_cdb_tag,
  output logic [XLEN-1:0]  exu_cdb_data,
  output logic             exu_busy
);

  exu_entry_t       ex_q, ex_d;
  exu_result_t      res_q [RES_DEPTH];
  exu_result_t      res_d [RES_DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_after_pop;
  logic [XLEN-1:0]  alu_result;
  logic             cdb_fire;
  logic             ex_adv;
  logic             res_has_room;

  int_alu u_alu (
    .opcode (ex_q.opcode),
    .a      (ex_q.rs_data),
    .b      (ex_q.rt_data),
    .result (alu_result)
  );

  // Handshake: gated by reset so nothing is broadcast or accepted in the reset cycle.
  always_comb begin
    res_has_room  = cnt_q < CNT_W'(RES_DEPTH);
    cdb_req       = ~reset & (cnt_q != '0);
    cdb_fire      = cdb_req & cdb_grant;
    ex_adv        = ex_q.valid & (res_has_room | cdb_fire);
    issueblk_done = ~reset & issueque_ready & (~ex_q.valid | ex_adv);
    exu_cdb_tag   = cdb_req ? res_q[0].rd_tag : '0;
    exu_cdb_data  = cdb_req ? res_q[0].data : '0;
    exu_busy      = ~reset & (ex_q.valid | (cnt_q != '0));
  end

  // EX register next state: capture on accept, otherwise drain on advance.
  always_comb begin
    ex_d = ex_q;
    if (issueblk_done) begin
      ex_d.valid   = 1'b1;
      ex_d.rd_tag  = issueque_rd_tag;
      ex_d.opcode  = alu_op_e'(issueque_opcode);
      ex_d.rs_data = issueque_rs_data;
      ex_d.rt_data = issueque_rt_data;
    end else if (ex_adv) begin
      ex_d.valid = 1'b0;
    end
  end

  // Shifting FIFO: head at index 0; pop shifts down first, then push lands at the new tail.
  always_comb begin
    res_d         = res_q;
    cnt_after_pop = cnt_q;
    if (cdb_fire) begin
      for (int i = 0; i < int'(RES_DEPTH) - 1; i++) begin
        res_d[i] = res_q[i+1];
      end
      cnt_after_pop = cnt_q - 1'b1;
    end
    cnt_d = cnt_after_pop;
    if (ex_adv) begin
      for (int i = 0; i < int'(RES_DEPTH); i++) begin
        if (CNT_W'(i) == cnt_after_pop) begin
          res_d[i].rd_tag = ex_q.rd_tag;
          res_d[i].data   = alu_result;
        end
      end
      cnt_d = cnt_after_pop + 1'b1;
    end
  end

  // State registers with synchronous reset discarding EX and all buffered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RES_DEPTH); i++) begin
        res_q[i] <= '0;
      end
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

endmodule
